// File: rtl/matmul_loader_if.sv
// -----------------------------------------------------------------------------
// matmul_loader_if
//
// Purpose:
//   Groups the byte-stream handshake and the operand-memory write bus used by
//   matmul_loader into one bundle.
//
// Signals:
//   s_valid       stream byte valid             (producer -> loader)
//   s_data[7:0]   stream byte                   (producer -> loader)
//   s_ready       byte accepted on valid&ready  (loader -> producer)
//   mem_en_write  one-cycle write strobe        (loader -> memory)
//   mem_addr[9:0] write word address            (loader -> memory)
//   mem_data[31:0] write data                   (loader -> memory)
//
// Modports:
//   slave  : the loader's view (sinks the stream, sources the memory writes).
//   master : the environment's view (sources the stream, observes the writes).
// -----------------------------------------------------------------------------
interface matmul_loader_if;

  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;

  logic        mem_en_write;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready,
    output mem_en_write,
    output mem_addr,
    output mem_data
  );

  modport master (
    output s_valid,
    output s_data,
    input  s_ready,
    input  mem_en_write,
    input  mem_addr,
    input  mem_data
  );

endinterface : matmul_loader_if

// File: rtl/matmul_loader.sv
// -----------------------------------------------------------------------------
// matmul_loader
//
// Purpose:
//   Upstream feeder for the 4x4 matmul / average-pool engine. Takes a byte
//   stream holding matrix A (row-major) followed by matrix B (row-major).
//   A rows are packed straight into 32-bit words and written as they complete;
//   B is transposed into column words in a local buffer and flushed after the
//   last byte. Writes land at BASE_A+row and BASE_B+column.
//
// Parameters:
//   BASE_A  word address of A row 0 (rows at BASE_A+0..3)
//   BASE_B  word address of B column 0 (columns at BASE_B+0..3)
//
// Ports:
//   clk         single clock, rising edge
//   rstn        asynchronous active-low reset
//   start       one-cycle load request (honoured only in IDLE with mm_ready)
//   mm_ready    engine idle indication
//   bus         matmul_loader_if.slave: stream in (s_valid/s_data/s_ready),
//               memory write out (mem_en_write/mem_addr/mem_data)
//   kick_start  one-cycle start pulse to the engine
//   busy        high whenever the state is not IDLE
//   done        one-cycle pulse marking load completion
//
// Build option:
//   MATMUL_LOADER_AUTO_KICK_EN
//     defined   : KICK state exists; after the B flush the block waits for
//                 mm_ready and pulses kick_start together with done.
//     undefined : no KICK state; kick_start is tied low and done pulses in
//                 the cycle of the last B write.
// -----------------------------------------------------------------------------
module matmul_loader #(
  parameter logic [9:0] BASE_A = 10'h000,
  parameter logic [9:0] BASE_B = 10'h100
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             mm_ready,
  matmul_loader_if.slave   bus,
  output logic             kick_start,
  output logic             busy,
  output logic             done
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
`ifdef MATMUL_LOADER_AUTO_KICK_EN
    FLUSH_B = 3'd3,
    KICK    = 3'd4
`else
    FLUSH_B = 3'd3
`endif
  } state_t;

  state_t            state_q, state_d;

  // Byte counter: byte index within the current matrix while loading,
  // column index (low two bits) while flushing B.
  logic [3:0]        bcnt_q, bcnt_d;

  // Lanes 0..2 of the A row being assembled; lane 3 goes straight from
  // s_data into the write word, so it is never stored.
  logic [23:0]       pack_q, pack_d;

  // Transposed B: bbuf_q[c] = {B[3][c], B[2][c], B[1][c], B[0][c]}.
  logic [3:0][31:0]  bbuf_q, bbuf_d;

  // Registered memory-write outputs.
  logic              wr_en_q,   wr_en_d;
  logic [9:0]        wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;

  logic              done_q, done_d;

`ifdef MATMUL_LOADER_AUTO_KICK_EN
  logic              kick_q, kick_d;
`endif

  // ---------------------------------------------------------------------------
  // Stream handshake
  // ---------------------------------------------------------------------------
  logic s_ready_int;
  logic a_accept;
  logic b_accept;

  assign s_ready_int = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign a_accept    = bus.s_valid && (state_q == LOAD_A);
  assign b_accept    = bus.s_valid && (state_q == LOAD_B);

  // ---------------------------------------------------------------------------
  // A pack lanes: each accepted A byte lands in lane bcnt[1:0].
  // ---------------------------------------------------------------------------
  genvar gi, gj;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_pack_lane
      assign pack_d[gi*8 +: 8] =
        (a_accept && (bcnt_q[1:0] == 2'(gi))) ? bus.s_data : pack_q[gi*8 +: 8];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // B transpose buffer: byte k (row r = k[3:2], column c = k[1:0]) goes to
  // column word c, lane r. Each byte slot has its own decode so the store is
  // a plain byte-enable per slot rather than a shifter.
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bcol
      for (gj = 0; gj < 4; gj++) begin : g_blane
        assign bbuf_d[gi][gj*8 +: 8] =
          (b_accept && (bcnt_q == 4'(gj*4 + gi))) ? bus.s_data
                                                   : bbuf_q[gi][gj*8 +: 8];
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
`ifdef MATMUL_LOADER_AUTO_KICK_EN
    kick_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // A start while the engine is busy is dropped, not remembered.
        if (start && mm_ready) begin
          state_d = LOAD_A;
          bcnt_d  = 4'd0;
        end
      end

      LOAD_A: begin
        if (a_accept) begin
          bcnt_d = bcnt_q + 4'd1;
          // Lane 3 completes a row: write it next cycle using the live byte
          // for the top lane.
          if (bcnt_q[1:0] == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_addr_d = BASE_A + {8'd0, bcnt_q[3:2]};
            wr_data_d = {bus.s_data, pack_q};
          end
          if (bcnt_q == 4'd15) begin
            state_d = LOAD_B;
          end
        end
      end

      LOAD_B: begin
        if (b_accept) begin
          bcnt_d = bcnt_q + 4'd1;
          if (bcnt_q == 4'd15) begin
            state_d = FLUSH_B;
          end
        end
      end

      FLUSH_B: begin
        // bcnt wrapped to 0 on entry; its low bits walk the columns.
        wr_en_d   = 1'b1;
        wr_addr_d = BASE_B + {8'd0, bcnt_q[1:0]};
        wr_data_d = bbuf_q[bcnt_q[1:0]];
        bcnt_d    = bcnt_q + 4'd1;
        if (bcnt_q[1:0] == 2'd3) begin
          bcnt_d = 4'd0;
`ifdef MATMUL_LOADER_AUTO_KICK_EN
          state_d = KICK;
`else
          // done is registered, so it shows up alongside the last B write.
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end
      end

`ifdef MATMUL_LOADER_AUTO_KICK_EN
      KICK: begin
        if (mm_ready) begin
          kick_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      bcnt_q    <= 4'd0;
      pack_q    <= 24'd0;
      bbuf_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 10'd0;
      wr_data_q <= 32'd0;
      done_q    <= 1'b0;
`ifdef MATMUL_LOADER_AUTO_KICK_EN
      kick_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      pack_q    <= pack_d;
      bbuf_q    <= bbuf_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
`ifdef MATMUL_LOADER_AUTO_KICK_EN
      kick_q    <= kick_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.s_ready      = s_ready_int;
  assign bus.mem_en_write = wr_en_q;
  assign bus.mem_addr     = wr_addr_q;
  assign bus.mem_data     = wr_data_q;

  assign busy = (state_q != IDLE);
  assign done = done_q;

`ifdef MATMUL_LOADER_AUTO_KICK_EN
  assign kick_start = kick_q;
`else
  assign kick_start = 1'b0;
`endif

endmodule : matmul_loader

// File: tb/tb_matmul_loader.sv
// -----------------------------------------------------------------------------
// tb_matmul_loader
//
// Directed bench for matmul_loader: basic load, stream gaps, busy engine,
// reset mid-load and start while busy. Expected write words are the
// hand-computed row/column packings of bytes 0x01..0x20.
// -----------------------------------------------------------------------------
module tb_matmul_loader;

  logic clk      = 1'b0;
  logic rstn     = 1'b0;
  logic start    = 1'b0;
  logic mm_ready = 1'b1;
  logic kick_start;
  logic busy;
  logic done;

  matmul_loader_if bus ();

  matmul_loader dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .mm_ready   (mm_ready),
    .bus        (bus),
    .kick_start (kick_start),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0]  exp_addr [8] = '{10'h000, 10'h001, 10'h002, 10'h003,
                                10'h100, 10'h101, 10'h102, 10'h103};
  logic [31:0] exp_data [8] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D,
                                32'h1D191511, 32'h1E1A1612, 32'h1F1B1713, 32'h201C1814};

  // ---------------------------------------------------------------------------
  // Monitor (samples on the falling edge)
  // ---------------------------------------------------------------------------
  int          wr_cyc    [$];
  logic [9:0]  wr_addr   [$];
  logic [31:0] wr_data   [$];
  int          done_cyc  [$];
  int          kick_cyc  [$];
  int          busy_fall [$];
  int          rdy_rise  [$];
  logic        busy_prev = 1'b0;
  logic        rdy_prev  = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_en_write) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_data);
      $display("wr  cyc=%0d addr=%03h data=%08h", cyc, bus.mem_addr, bus.mem_data);
    end
    if (done)       done_cyc.push_back(cyc);
    if (kick_start) kick_cyc.push_back(cyc);
    if (busy_prev && !busy)         busy_fall.push_back(cyc);
    if (!rdy_prev && bus.s_ready)   rdy_rise.push_back(cyc);
    busy_prev = busy;
    rdy_prev  = bus.s_ready;
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wr_cyc.delete();  wr_addr.delete(); wr_data.delete();
    done_cyc.delete(); kick_cyc.delete(); busy_fall.delete(); rdy_rise.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns the cycle in which start was high.
  task automatic pulse_start(output int s);
    start = 1'b1;
    s     = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    @(negedge clk);
    while (!bus.s_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) check("s_ready_timeout", 32'(bus.s_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic do_load(input bit gaps, input bit poke_start, input bit hold_engine,
                         output int s);
    clear_mon();
    mm_ready = 1'b1;
    pulse_start(s);
    if (hold_engine) mm_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (poke_start && i == 19) start = 1'b1;
      send_byte(8'(i + 1));
      start = 1'b0;
      if (gaps && (i == 1 || i == 14 || i == 19)) repeat (3) tick();
    end
    if (poke_start) begin
      // Now in FLUSH_B: two start pulses that must be ignored.
      start = 1'b1; tick();
      start = 1'b0; tick();
      start = 1'b1; tick();
      start = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag, input int limit);
    int t;
    t = 0;
    while (done_cyc.size() == 0 && t < limit) begin
      tick();
      t++;
    end
    check({tag, "_done_seen"}, 32'(done_cyc.size() > 0), 32'd1);
    repeat (4) tick();
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd8);
    for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), 32'(exp_addr[i]));
      check($sformatf("%s_data%0d", tag, i), wr_data[i], exp_data[i]);
    end
    check({tag, "_ndone"}, 32'(done_cyc.size()), 32'd1);
`ifdef MATMUL_LOADER_AUTO_KICK_EN
    check({tag, "_nkick"}, 32'(kick_cyc.size()), 32'd1);
`else
    check({tag, "_nkick"}, 32'(kick_cyc.size()), 32'd0);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(bus.s_ready),      32'd0);
    check({tag, "_wr_en"},   32'(bus.mem_en_write), 32'd0);
    check({tag, "_addr"},    32'(bus.mem_addr),     32'd0);
    check({tag, "_data"},    bus.mem_data,          32'd0);
    check({tag, "_kick"},    32'(kick_start),       32'd0);
    check({tag, "_busy"},    32'(busy),             32'd0);
    check({tag, "_done"},    32'(done),             32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int s;
    int x;
    int n_hi;

    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rstn = 1'b1;
    tick();
    tick();

    // Basic load with timing
    do_load(1'b0, 1'b0, 1'b0, s);
    wait_done("basic", 20);
    check_writes("basic");
    if (rdy_rise.size() > 0) check("basic_rdy_rise", 32'(rdy_rise[0]), 32'(s + 1));
    if (wr_cyc.size() == 8) begin
      check("basic_wr0_cyc", 32'(wr_cyc[0]), 32'(s + 5));
      check("basic_wr3_cyc", 32'(wr_cyc[3]), 32'(s + 17));
      check("basic_wr4_cyc", 32'(wr_cyc[4]), 32'(s + 34));
      check("basic_wr7_cyc", 32'(wr_cyc[7]), 32'(s + 37));
    end
`ifdef MATMUL_LOADER_AUTO_KICK_EN
    if (done_cyc.size() > 0)  check("basic_done_cyc", 32'(done_cyc[0]),  32'(s + 38));
    if (kick_cyc.size() > 0)  check("basic_kick_cyc", 32'(kick_cyc[0]),  32'(s + 38));
    if (busy_fall.size() > 0) check("basic_busy_fall", 32'(busy_fall[0]), 32'(s + 38));
`else
    if (done_cyc.size() > 0)  check("basic_done_cyc", 32'(done_cyc[0]),  32'(s + 37));
    if (busy_fall.size() > 0) check("basic_busy_fall", 32'(busy_fall[0]), 32'(s + 37));
`endif

    // Stream gaps
    do_load(1'b1, 1'b0, 1'b0, s);
    wait_done("gap", 20);
    check_writes("gap");

    // start while the engine is busy is ignored
    clear_mon();
    mm_ready = 1'b0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("nostart_busy%0d", i),    32'(busy),        32'd0);
      check($sformatf("nostart_s_ready%0d", i), 32'(bus.s_ready), 32'd0);
      tick();
    end
    mm_ready = 1'b1;

    // Completed load while the engine stays busy
    do_load(1'b0, 1'b0, 1'b1, s);
    while (cyc < s + 45) tick();
`ifdef MATMUL_LOADER_AUTO_KICK_EN
    check("hold_busy", 32'(busy), 32'd1);
    check("hold_nkick_before", 32'(kick_cyc.size()), 32'd0);
`else
    check("hold_busy", 32'(busy), 32'd0);
`endif
    x = cyc;
    mm_ready = 1'b1;
    wait_done("hold", 10);
    check_writes("hold");
`ifdef MATMUL_LOADER_AUTO_KICK_EN
    if (kick_cyc.size() > 0) check("hold_kick_cyc", 32'(kick_cyc[0]), 32'(x + 1));
`else
    if (done_cyc.size() > 0) check("hold_done_cyc", 32'(done_cyc[0]), 32'(s + 37));
`endif

    // Reset mid-load (after byte 20, in LOAD_B)
    clear_mon();
    pulse_start(s);
    for (int i = 0; i < 20; i++) send_byte(8'(i + 1));
    rstn = 1'b0;
    #2;
    check_idle_outputs("midrst");
    tick();
    tick();
    rstn = 1'b1;
    repeat (6) tick();
    n_hi = 0;
    foreach (wr_addr[i]) if (wr_addr[i][8]) n_hi++;
    check("midrst_n_b_writes", 32'(n_hi), 32'd0);
    check("midrst_n_writes", 32'(wr_addr.size()), 32'd4);
    check("midrst_ndone", 32'(done_cyc.size()), 32'd0);
    do_load(1'b0, 1'b0, 1'b0, s);
    wait_done("after_rst", 20);
    check_writes("after_rst");

    // start pulsed during LOAD_B and FLUSH_B
    do_load(1'b0, 1'b1, 1'b0, s);
    wait_done("poke", 20);
    repeat (4) tick();
    check_writes("poke");
    check("poke_busy_after", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_matmul_loader

// File: doc/matmul_loader.md
# matmul_loader

Upstream feeder for the 4x4 matmul/average-pool engine. Accepts a byte stream holding matrix A (row-major) then matrix B (row-major) on a valid/ready interface. It packs A rows directly into 32-bit words and transposes B into column words, then writes both into the shared operand memory at the engine's base addresses. Optionally, it fires the engine's `kick_start` once all writes have landed.

## Interface

Parameters:
- `BASE_A`, 10'h000: word address of A row 0; rows at `BASE_A+0..3`.
- `BASE_B`, 10'h100: word address of B column 0; columns at `BASE_B+0..3`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load.
- `mm_ready`  in  1  engine `ready`; high = engine idle.
- `s_valid`  in  1  stream byte valid.
- `s_data`  in  8  stream byte.
- `s_ready`  out  1  stream byte accepted when `s_valid & s_ready`.
- `mem_en_write`  out  1  operand memory write strobe.
- `mem_addr`  out  10  write word address.
- `mem_data`  out  32  write data.
- `kick_start`  out  1  one-cycle start pulse to the engine.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse marking load completion.

## Operation

- **States:** IDLE, LOAD_A, LOAD_B, FLUSH_B, KICK (KICK exists only with the macro).
- **IDLE:**
  - `s_ready`=0.
  - `start & mm_ready` moves to LOAD_A and clears the byte counter `bcnt[3:0]`.
  - `start` with `mm_ready`=0 is ignored, not latched.
- **LOAD_A:**
  - `s_ready`=1.
  - Each handshake stores `s_data` in pack lane `bcnt[1:0]` (lane0 = bits[7:0]) and increments `bcnt`.
  - When the handshake on lane 3 is accepted, the next cycle drives a write with `mem_addr=BASE_A+bcnt[3:2]` and `mem_data={s_data, pack[23:0]}`.
  - After 16 bytes, `bcnt` wraps to 0 and the state moves to LOAD_B.
- **LOAD_B:**
  - `s_ready`=1.
  - Byte k (r=k[3:2], c=k[1:0]) is stored into `bbuf[c]` lane r, so word c = {B[3][c],B[2][c],B[1][c],B[0][c]}.
  - No writes are issued, except the A row 3 write, which lands in the first LOAD_B cycle.
  - After 16 bytes, move to FLUSH_B.
- **FLUSH_B:**
  - `s_ready`=0.
  - Issues one write per cycle for c=0..3, with `mem_addr=BASE_B+c` and `mem_data=bbuf[c]`.
  - Then moves to KICK (macro on) or IDLE (macro off).
- **KICK:**
  - Waits for `mm_ready`=1.
  - Then pulses `kick_start` and `done` together for one cycle and returns to IDLE.
- **Stalls:** `s_valid`=0 stalls LOAD_A/LOAD_B indefinitely with no state change. There is no timeout.
- **`start` while busy:** ignored.
- **Mid-operation reset:** all state is discarded. Any in-flight write strobe drops immediately. Partial matrices are not completed.

## Timing

- **Reset values:**
  - `s_ready`=0, `mem_en_write`=0, `mem_addr`=0, `mem_data`=0.
  - `kick_start`=0, `busy`=0, `done`=0.
  - State=IDLE, `bcnt`=0, `bbuf` and pack register=0.
- **Registered outputs:** all memory outputs are registered. Each write strobe is high exactly one cycle.
- **A writes:** each A row write appears 1 cycle after its 4th byte handshake.
- **IDLE exit:** LOAD_A is entered the cycle after `start & mm_ready`, so `s_ready` rises 1 cycle after `start`.
- **B flush:** let T be the first FLUSH_B cycle. B writes appear at T+1..T+4.
- **Completion, macro on:** earliest `kick_start`/`done` is at T+5, after the last write. `busy` falls at T+5.
- **Completion, macro off:** the state is IDLE at T+4. `done` pulses at T+4, coinciding with the last B write. `busy` falls at T+4.
- **Best case:** with `s_valid` held high, a full load takes 32 accept cycles plus 5 (macro off) or 6 (macro on) cycles from the `start` cycle.

## Configuration

- Macro: `MATMUL_LOADER_AUTO_KICK_EN`.
- **Defined:** the KICK state exists; `kick_start` is driven as specified.
- **Undefined:**
  - No KICK state; `kick_start` is tied to 0.
  - FLUSH_B returns directly to IDLE with the `done` pulse.
  - `mm_ready` is used only to qualify `start`.

## Test plan

- **Basic load:** `start` with `mm_ready`=1, then bytes 0x01..0x10 followed by 0x11..0x20 with `s_valid` continuously high.
  - Writes 0x000=0x04030201, 0x001=0x08070605, 0x002=0x0C0B0A09, 0x003=0x100F0E0D.
  - Then 0x100=0x1D191511, 0x101=0x1E1A1612, 0x102=0x1F1B1713, 0x103=0x201C1814.
  - Then `kick_start`/`done` at T+5.
- **Stream gaps:** same data, with `s_valid` dropped for 3 cycles after bytes 2, 15 and 20. Write addresses and data are identical to the basic load; no spurious strobes occur during stalls.
- **Busy engine:**
  - `start` while `mm_ready`=0: `busy` stays 0 and `s_ready` stays 0.
  - Completed load while `mm_ready`=0 (macro on): the block holds in KICK with `busy`=1. `kick_start` fires 1 cycle after `mm_ready` rises.
- **Reset mid-load:** assert `rstn`=0 after byte 20 (mid LOAD_B). All outputs return to reset values immediately and no 0x1xx write occurs. A following full load produces the basic-load results.
- **`start` while busy:** `start` pulsed during LOAD_B and FLUSH_B has no effect. Exactly 8 writes and one `done` occur.
- **Macro undefined:** the basic-load stimulus gives identical writes, with `done` at T+4 and `kick_start` never asserted.
